// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator front end.
//   - calc_state_t : sequencer states
//   - OPC_*        : ALU operation codes (compared after sizing to OP_W)
//   - DISP_*/LEDS_*: display-select and progress-LED codes per state
//   - calc_flags_t : latched ALU flag bundle
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RESULT = 3'd3,
    CHAIN  = 3'd4
  } calc_state_t;

  localparam int OPC_ADD   = 0;
  localparam int OPC_SUB   = 1;
  localparam int OPC_AND   = 2;
  localparam int OPC_OR    = 3;
  localparam int OPC_XOR   = 4;
  localparam int OPC_NOT_A = 5;
  localparam int OPC_SHL   = 6;
  localparam int OPC_SHR   = 7;

  localparam logic [2:0] DISP_IDLE   = 3'b100;
  localparam logic [2:0] DISP_LOAD_A = 3'b001;
  localparam logic [2:0] DISP_LOAD_B = 3'b010;
  localparam logic [2:0] DISP_RESULT = 3'b011;
  localparam logic [2:0] DISP_CHAIN  = 3'b101;

  localparam logic [3:0] LEDS_IDLE   = 4'b0001;
  localparam logic [3:0] LEDS_LOAD_A = 4'b0011;
  localparam logic [3:0] LEDS_LOAD_B = 4'b0111;
  localparam logic [3:0] LEDS_RESULT = 4'b1111;
  localparam logic [3:0] LEDS_CHAIN  = 4'b0011;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } calc_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU for the calculator.
//   a, b     : WIDTH-bit operands
//   op       : OP_W-bit operation code (OPC_* in calc_pkg)
//   result   : WIDTH-bit result, modulo 2^WIDTH
//   zero     : result == 0
//   carry    : ADD carry-out / SUB no-borrow, 0 otherwise
//   overflow : signed two's-complement overflow for ADD/SUB, 0 otherwise
// Shifts move by one bit position. Undefined opcodes give result 0.
module alu_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    sum      = '0;
    case (op)
      OP_W'(OPC_ADD): begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[MSB:0];
        carry    = sum[WIDTH];
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_W'(OPC_SUB): begin
        // Extra top bit of the widened difference is the borrow.
        sum      = {1'b0, a} - {1'b0, b};
        result   = sum[MSB:0];
        carry    = ~sum[WIDTH];
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_W'(OPC_AND):   result = a & b;
      OP_W'(OPC_OR):    result = a | b;
      OP_W'(OPC_XOR):   result = a ^ b;
      OP_W'(OPC_NOT_A): result = ~a;
      OP_W'(OPC_SHL):   result = {a[MSB-1:0], 1'b0};
      OP_W'(OPC_SHR):   result = {1'b0, a[MSB:1]};
      default:          result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand-entry sequencer for the switch/button calculator.
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   switches    : operand in [WIDTH-1:0], opcode in [WIDTH+OP_W-1:WIDTH]
//   enter/clear : level buttons, active-high
//   value_out   : displayed value
//   display_sel : display mode code (DISP_*)
//   leds        : progress LEDs (LEDS_*)
//   zero/carry_out/overflow : ALU flags latched while in RESULT
// Build option CALC_INPUT_SYNC_EN: when defined, enter and clear pass
// through 2-flop synchronizers before use (+2 cycles latency).
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH+OP_W-1:0] switches,
  input  logic                  enter,
  input  logic                  clear,
  output logic [WIDTH-1:0]      value_out,
  output logic [2:0]            display_sel,
  output logic [3:0]            leds,
  output logic                  zero,
  output logic                  carry_out,
  output logic                  overflow
);

  logic enter_s, clear_s;

`ifdef CALC_INPUT_SYNC_EN
  logic [1:0] enter_sync_q, clear_sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enter_sync_q <= '0;
      clear_sync_q <= '0;
    end else begin
      enter_sync_q <= {enter_sync_q[0], enter};
      clear_sync_q <= {clear_sync_q[0], clear};
    end
  end

  assign enter_s = enter_sync_q[1];
  assign clear_s = clear_sync_q[1];
`else
  assign enter_s = enter;
  assign clear_s = clear;
`endif

  calc_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OP_W-1:0]  op_q, op_d;
  calc_flags_t      flags_q, flags_d;
  logic             enter_q;
  logic             press;

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_carry, alu_ovf;

  alu_core #(.WIDTH(WIDTH), .OP_W(OP_W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .carry    (alu_carry),
    .overflow (alu_ovf)
  );

  // One press per rising edge of enter, however long it is held.
  assign press = enter_s & ~enter_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      enter_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      enter_q  <= enter_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (clear_s) begin
      state_d  = IDLE;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      flags_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (press) begin
          a_d     = switches[WIDTH-1:0];
          state_d = LOAD_A;
        end
        LOAD_A: if (press) begin
          b_d     = switches[WIDTH-1:0];
          state_d = LOAD_B;
        end
        LOAD_B: if (press) begin
          op_d    = switches[WIDTH+OP_W-1:WIDTH];
          state_d = RESULT;
        end
        RESULT: begin
          result_d = alu_result;
          flags_d  = '{zero: alu_zero, carry: alu_carry, ovf: alu_ovf};
          // Chain from the live ALU output so a press on the first
          // RESULT cycle never picks up a stale result_q.
          if (press) begin
            a_d     = alu_result;
            state_d = CHAIN;
          end
        end
        CHAIN: if (press) begin
          b_d     = switches[WIDTH-1:0];
          state_d = LOAD_B;
        end
        default: begin
          state_d  = IDLE;
          a_d      = '0;
          b_d      = '0;
          op_d     = '0;
          result_d = '0;
          flags_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    value_out   = '0;
    display_sel = DISP_IDLE;
    leds        = LEDS_IDLE;
    case (state_q)
      LOAD_A: begin value_out = a_q;      display_sel = DISP_LOAD_A; leds = LEDS_LOAD_A; end
      LOAD_B: begin value_out = b_q;      display_sel = DISP_LOAD_B; leds = LEDS_LOAD_B; end
      RESULT: begin value_out = result_q; display_sel = DISP_RESULT; leds = LEDS_RESULT; end
      CHAIN:  begin value_out = a_q;      display_sel = DISP_CHAIN;  leds = LEDS_CHAIN;  end
      default: ;
    endcase
  end

  assign zero      = flags_q.zero;
  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.ovf;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or a few ns after it for the asynchronous-reset case).
module tb_calc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] switches;
  logic        enter, clear;
  logic [7:0]  value_out;
  logic [2:0]  display_sel;
  logic [3:0]  leds;
  logic        zero, carry_out, overflow;

  int checks = 0;
  int failures = 0;

  calc_sequencer #(.WIDTH(8), .OP_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .switches    (switches),
    .enter       (enter),
    .clear       (clear),
    .value_out   (value_out),
    .display_sel (display_sel),
    .leds        (leds),
    .zero        (zero),
    .carry_out   (carry_out),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // One-cycle enter pulse, then enter low for at least one full cycle.
  task automatic press(input logic [11:0] sw);
    @(negedge clock); switches = sw; enter = 1'b1;
    @(negedge clock); enter = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enter = 1'b0; clear = 1'b0; switches = '0;
    repeat (2) @(negedge clock);
    checks++; if (value_out !== 8'h00) begin failures++; $display("FAIL reset_value got=%h exp=00", value_out); end
    checks++; if (display_sel !== 3'b100) begin failures++; $display("FAIL reset_disp got=%b exp=100", display_sel); end
    checks++; if (leds !== 4'b0001) begin failures++; $display("FAIL reset_leds got=%b exp=0001", leds); end
    checks++; if ({zero, carry_out, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {zero, carry_out, overflow}); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_add();
    press(12'h005);
    checks++; if (display_sel !== 3'b001) begin failures++; $display("FAIL add_loada_disp got=%b exp=001", display_sel); end
    checks++; if (leds !== 4'b0011) begin failures++; $display("FAIL add_loada_leds got=%b exp=0011", leds); end
    checks++; if (value_out !== 8'h05) begin failures++; $display("FAIL add_loada_value got=%h exp=05", value_out); end
    press(12'h003);
    checks++; if (display_sel !== 3'b010) begin failures++; $display("FAIL add_loadb_disp got=%b exp=010", display_sel); end
    checks++; if (leds !== 4'b0111) begin failures++; $display("FAIL add_loadb_leds got=%b exp=0111", leds); end
    checks++; if (value_out !== 8'h03) begin failures++; $display("FAIL add_loadb_value got=%h exp=03", value_out); end
    press({4'd0, 8'h00});
    checks++; if (display_sel !== 3'b011) begin failures++; $display("FAIL add_result_disp got=%b exp=011", display_sel); end
    checks++; if (leds !== 4'b1111) begin failures++; $display("FAIL add_result_leds got=%b exp=1111", leds); end
    @(negedge clock);
    checks++; if (value_out !== 8'h08) begin failures++; $display("FAIL add_value got=%h exp=08", value_out); end
    checks++; if ({zero, carry_out, overflow} !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", {zero, carry_out, overflow}); end
  endtask

  task automatic test_chain();
    press(12'h0AA);
    checks++; if (display_sel !== 3'b101) begin failures++; $display("FAIL chain_disp got=%b exp=101", display_sel); end
    checks++; if (leds !== 4'b0011) begin failures++; $display("FAIL chain_leds got=%b exp=0011", leds); end
    checks++; if (value_out !== 8'h08) begin failures++; $display("FAIL chain_value got=%h exp=08", value_out); end
    press(12'h002);
    checks++; if (display_sel !== 3'b010) begin failures++; $display("FAIL chain_loadb_disp got=%b exp=010", display_sel); end
    checks++; if (value_out !== 8'h02) begin failures++; $display("FAIL chain_loadb_value got=%h exp=02", value_out); end
    press({4'd1, 8'h00});
    @(negedge clock);
    checks++; if (value_out !== 8'h06) begin failures++; $display("FAIL sub_value got=%h exp=06", value_out); end
    checks++; if ({zero, carry_out, overflow} !== 3'b010) begin failures++; $display("FAIL sub_flags got=%b exp=010", {zero, carry_out, overflow}); end
  endtask

  task automatic test_overflow();
    do_clear();
    press(12'h07F); press(12'h001); press({4'd0, 8'h00});
    @(negedge clock);
    checks++; if (value_out !== 8'h80) begin failures++; $display("FAIL ovf_value got=%h exp=80", value_out); end
    checks++; if ({zero, carry_out, overflow} !== 3'b001) begin failures++; $display("FAIL ovf_flags got=%b exp=001", {zero, carry_out, overflow}); end
    do_clear();
    press(12'h0FF); press(12'h001); press({4'd0, 8'h00});
    @(negedge clock);
    checks++; if (value_out !== 8'h00) begin failures++; $display("FAIL carry_value got=%h exp=00", value_out); end
    checks++; if ({zero, carry_out, overflow} !== 3'b110) begin failures++; $display("FAIL carry_flags got=%b exp=110", {zero, carry_out, overflow}); end
    // Flags stay latched after leaving RESULT.
    press(12'h000);
    checks++; if ({zero, carry_out, overflow} !== 3'b110) begin failures++; $display("FAIL held_flags_chain got=%b exp=110", {zero, carry_out, overflow}); end
    press(12'h004);
    checks++; if ({zero, carry_out, overflow} !== 3'b110) begin failures++; $display("FAIL held_flags_loadb got=%b exp=110", {zero, carry_out, overflow}); end
  endtask

  task automatic test_clear_priority();
    // Currently in LOAD_B with flags 110.
    @(negedge clock); clear = 1'b1; enter = 1'b1; switches = {4'd1, 8'h00};
    @(negedge clock); clear = 1'b0; enter = 1'b0;
    checks++; if (display_sel !== 3'b100) begin failures++; $display("FAIL clr_disp got=%b exp=100", display_sel); end
    checks++; if (leds !== 4'b0001) begin failures++; $display("FAIL clr_leds got=%b exp=0001", leds); end
    checks++; if (value_out !== 8'h00) begin failures++; $display("FAIL clr_value got=%h exp=00", value_out); end
    checks++; if ({zero, carry_out, overflow} !== 3'b000) begin failures++; $display("FAIL clr_flags got=%b exp=000", {zero, carry_out, overflow}); end
    @(negedge clock);
    checks++; if (display_sel !== 3'b100) begin failures++; $display("FAIL clr_stay_idle got=%b exp=100", display_sel); end
  endtask

  task automatic test_hold();
    @(negedge clock); switches = 12'h011; enter = 1'b1;
    @(negedge clock); switches = 12'h022;
    repeat (19) @(negedge clock);
    checks++; if (display_sel !== 3'b001) begin failures++; $display("FAIL hold_disp got=%b exp=001", display_sel); end
    checks++; if (value_out !== 8'h11) begin failures++; $display("FAIL hold_value got=%h exp=11", value_out); end
    enter = 1'b0;
    @(negedge clock);
    checks++; if (display_sel !== 3'b001) begin failures++; $display("FAIL hold_release_disp got=%b exp=001", display_sel); end
    press(12'h033);
    checks++; if (display_sel !== 3'b010) begin failures++; $display("FAIL hold_next_disp got=%b exp=010", display_sel); end
    checks++; if (value_out !== 8'h33) begin failures++; $display("FAIL hold_next_value got=%h exp=33", value_out); end
  endtask

  task automatic test_reset_mid();
    // In LOAD_B showing 0x33; drop reset between edges of a press cycle.
    @(negedge clock); switches = {4'd0, 8'h00}; enter = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (value_out !== 8'h00) begin failures++; $display("FAIL rstmid_value got=%h exp=00", value_out); end
    checks++; if (display_sel !== 3'b100) begin failures++; $display("FAIL rstmid_disp got=%b exp=100", display_sel); end
    checks++; if (leds !== 4'b0001) begin failures++; $display("FAIL rstmid_leds got=%b exp=0001", leds); end
    @(negedge clock); enter = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    checks++; if (display_sel !== 3'b100) begin failures++; $display("FAIL rstmid_after_disp got=%b exp=100", display_sel); end
    press(12'h009);
    checks++; if (value_out !== 8'h09) begin failures++; $display("FAIL rstmid_reload got=%h exp=09", value_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_overflow();
    test_clear_priority();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
